// File: rtl/qos_fifo_drain.sv
// Round-robin drain for the four QoS virtual-channel FIFOs: registered single-cycle pops,
// 2-cycle pop-to-delivery pipeline tagged with source port, and per-port delivered-word counters.
module qos_fifo_drain #(
    parameter int DATA_W = 12,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              sink_pause,
    input  logic [3:0]        fifo_empty,
    input  logic [DATA_W-1:0] fifo_dataout0,
    input  logic [DATA_W-1:0] fifo_dataout1,
    input  logic [DATA_W-1:0] fifo_dataout2,
    input  logic [DATA_W-1:0] fifo_dataout3,
    output logic              pop0,
    output logic              pop1,
    output logic              pop2,
    output logic              pop3,
    output logic [DATA_W-1:0] data_out,
    output logic [1:0]        port_out,
    output logic              valid_out,
    input  logic              req,
    input  logic [2:0]        idx,
    output logic              valid,
    output logic [CNT_W-1:0]  data
);

    logic [3:0]        pop_r;
    logic [1:0]        rr_ptr_r;
    logic              fly_v_r;
    logic [1:0]        fly_port_r;
    logic [DATA_W-1:0] data_out_r;
    logic [1:0]        port_out_r;
    logic              valid_out_r;
    logic [CNT_W-1:0]  cnt_r [4];
    logic [CNT_W-1:0]  total_r;
    logic              rd_valid_r;
    logic [CNT_W-1:0]  rd_data_r;

    logic [3:0]        elig_s;
    logic              grant_v_s;
    logic [1:0]        grant_s;
    logic [1:0]        cand_s;
    logic [3:0]        pop_next_s;
    logic [DATA_W-1:0] word_s;
    logic [CNT_W-1:0]  rd_sel_s;

    function automatic logic [1:0] port_of(input logic [3:0] onehot);
        case (onehot)
            4'b0010: port_of = 2'd1;
            4'b0100: port_of = 2'd2;
            4'b1000: port_of = 2'd3;
            default: port_of = 2'd0;
        endcase
    endfunction

    assign pop0      = pop_r[0];
    assign pop1      = pop_r[1];
    assign pop2      = pop_r[2];
    assign pop3      = pop_r[3];
    assign data_out  = data_out_r;
    assign port_out  = port_out_r;
    assign valid_out = valid_out_r;
    assign valid     = rd_valid_r;
    assign data      = rd_data_r;

    // Round-robin grant; a port popped this cycle is locked out because its empty flag may be stale.
    always_comb begin
        elig_s     = ~fifo_empty & ~pop_r & {4{enable & ~sink_pause}};
        grant_v_s  = 1'b0;
        grant_s    = rr_ptr_r;
        cand_s     = rr_ptr_r;
        pop_next_s = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            cand_s = rr_ptr_r + 2'(k);
            if (!grant_v_s && elig_s[cand_s]) begin
                grant_v_s = 1'b1;
                grant_s   = cand_s;
            end else begin
            end
        end
        if (grant_v_s) begin
            pop_next_s[grant_s] = 1'b1;
        end else begin
            pop_next_s = 4'b0000;
        end
    end

    // Selects the read data of the FIFO whose pop is one cycle old.
    always_comb begin
        case (fly_port_r)
            2'd0:    word_s = fifo_dataout0;
            2'd1:    word_s = fifo_dataout1;
            2'd2:    word_s = fifo_dataout2;
            2'd3:    word_s = fifo_dataout3;
            default: word_s = fifo_dataout0;
        endcase
    end

    // Counter read mux.
    always_comb begin
        case (idx)
            3'd0:    rd_sel_s = cnt_r[0];
            3'd1:    rd_sel_s = cnt_r[1];
            3'd2:    rd_sel_s = cnt_r[2];
            3'd3:    rd_sel_s = cnt_r[3];
            3'd4:    rd_sel_s = total_r;
            default: rd_sel_s = {CNT_W{1'b0}};
        endcase
    end

    // Pop strobes and round-robin pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pop_r    <= 4'b0000;
            rr_ptr_r <= 2'd0;
        end else begin
            pop_r <= pop_next_s;
            if (grant_v_s) begin
                rr_ptr_r <= grant_s + 2'd1;
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end

    // Two-stage delivery pipeline: port tag during the FIFO read cycle, then the captured word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fly_v_r     <= 1'b0;
            fly_port_r  <= 2'd0;
            valid_out_r <= 1'b0;
            data_out_r  <= {DATA_W{1'b0}};
            port_out_r  <= 2'd0;
        end else begin
            fly_v_r     <= |pop_r;
            fly_port_r  <= port_of(pop_r);
            valid_out_r <= fly_v_r;
            if (fly_v_r) begin
                data_out_r <= word_s;
                port_out_r <= fly_port_r;
            end else begin
                data_out_r <= data_out_r;
                port_out_r <= port_out_r;
            end
        end
    end

    // Delivered-word counters, wrapping, bumped the cycle after each delivery.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                cnt_r[i] <= {CNT_W{1'b0}};
            end
            total_r <= {CNT_W{1'b0}};
        end else if (valid_out_r) begin
            cnt_r[port_out_r] <= cnt_r[port_out_r] + CNT_W'(1);
            total_r           <= total_r + CNT_W'(1);
        end else begin
            total_r <= total_r;
        end
    end

    // Registered counter read port; samples counters before any same-edge increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_valid_r <= 1'b0;
            rd_data_r  <= {CNT_W{1'b0}};
        end else begin
            rd_valid_r <= req;
            rd_data_r  <= req ? rd_sel_s : {CNT_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_qos_fifo_drain.sv
// Scoreboard bench for qos_fifo_drain: behavioural FIFO models feed the drain, expected words
// and counter reads are queued by the stimulus and popped by an independent negedge monitor.
module tb_qos_fifo_drain;
    localparam int DW = 12;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          sink_pause = 1'b0;
    logic          req = 1'b0;
    logic [2:0]    idx = 3'd0;
    logic [3:0]    fifo_empty = 4'hF;
    logic [DW-1:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
    logic          pop0, pop1, pop2, pop3;
    logic [3:0]    pops;
    logic [DW-1:0] data_out;
    logic [1:0]    port_out;
    logic          valid_out;
    logic          valid;
    logic [CW-1:0] data;

    logic [DW-1:0] q0[$], q1[$], q2[$], q3[$];
    logic [13:0]   exp_q[$];
    logic [CW-1:0] rq[$];
    logic [13:0]   e_w;
    logic [CW-1:0] e_r;
    logic [DW-1:0] w;
    int            checks = 0;
    int            errors = 0;

    logic [DW-1:0] t2 [4][4] = '{'{12'h0FF, 12'h404, 12'h895, 12'hCAE},
                                 '{12'h15A, 12'h55A, 12'h95A, 12'hD5A},
                                 '{12'h25A, 12'h65A, 12'hA5A, 12'hE5A},
                                 '{12'h35A, 12'h75A, 12'hB5A, 12'hF5A}};

    qos_fifo_drain #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .enable(enable), .sink_pause(sink_pause),
        .fifo_empty(fifo_empty),
        .fifo_dataout0(d0), .fifo_dataout1(d1), .fifo_dataout2(d2), .fifo_dataout3(d3),
        .pop0(pop0), .pop1(pop1), .pop2(pop2), .pop3(pop3),
        .data_out(data_out), .port_out(port_out), .valid_out(valid_out),
        .req(req), .idx(idx), .valid(valid), .data(data)
    );

    assign pops = {pop3, pop2, pop1, pop0};

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load(input int p, input logic [DW-1:0] v);
        case (p)
            0: q0.push_back(v);
            1: q1.push_back(v);
            2: q2.push_back(v);
            default: q3.push_back(v);
        endcase
    endtask

    task automatic expect_word(input int p, input logic [DW-1:0] v);
        exp_q.push_back({2'(p), v});
    endtask

    // FIFO models: a pop sampled at the edge presents its word during the following cycle.
    always @(posedge clk) begin
        if (|pops) chk("pop_onehot", $countones(pops), 1);
        if (pop0) begin chk("underflow0", q0.size() > 0, 1); if (q0.size() > 0) begin w = q0.pop_front(); d0 <= w; end end
        if (pop1) begin chk("underflow1", q1.size() > 0, 1); if (q1.size() > 0) begin w = q1.pop_front(); d1 <= w; end end
        if (pop2) begin chk("underflow2", q2.size() > 0, 1); if (q2.size() > 0) begin w = q2.pop_front(); d2 <= w; end end
        if (pop3) begin chk("underflow3", q3.size() > 0, 1); if (q3.size() > 0) begin w = q3.pop_front(); d3 <= w; end end
        fifo_empty <= {q3.size() == 0, q2.size() == 0, q1.size() == 0, q0.size() == 0};
    end

    // Monitor: every delivered word and every counter read is matched against the queues.
    always @(negedge clk) begin
        if (reset && valid_out) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_word: got port %0d data %03h expected none", port_out, data_out);
            end else begin
                e_w = exp_q.pop_front();
                chk("word_data", data_out, e_w[11:0]);
                chk("word_port", port_out, e_w[13:12]);
            end
        end
        if (reset && valid) begin
            if (rq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_read: got %0h expected none", data);
            end else begin
                e_r = rq.pop_front();
                chk("cnt_read", data, e_r);
            end
        end
    end

    task automatic start_reset();
        reset = 1'b0;
        exp_q.delete(); rq.delete();
        q0.delete(); q1.delete(); q2.delete(); q3.delete();
    endtask

    task automatic release_reset();
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && q0.size() == 0 && q1.size() == 0 &&
                q2.size() == 0 && q3.size() == 0 && !valid_out) break;
        end
        chk("idle_outstanding", exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic rd(input logic [2:0] i, input logic [CW-1:0] ev);
        @(negedge clk); req = 1'b1; idx = i; rq.push_back(ev);
        @(negedge clk); req = 1'b0; idx = 3'd0;
        @(negedge clk);
        chk("rd_idle_valid", valid, 0);
        chk("rd_idle_data", data, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int consec, delivered, m;
        int vc[$];
        // Reset with loaded FIFOs, then 16-word full-rate round robin
        #1 reset = 1'b0;
        enable = 1'b1;
        for (int p = 0; p < 4; p++) for (int k = 0; k < 4; k++) load(p, t2[p][k]);
        for (int k = 0; k < 4; k++) for (int p = 0; p < 4; p++) expect_word(p, t2[p][k]);
        repeat (3) @(negedge clk);
        chk("rst_pops", pops, 0);
        chk("rst_valid_out", valid_out, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_port_out", port_out, 0);
        chk("rst_valid", valid, 0);
        chk("rst_data", data, 0);
        reset = 1'b1;
        @(negedge clk); chk("first_pop", pops, 4'b0001); chk("vo_c1", valid_out, 0);
        @(negedge clk); chk("second_pop", pops, 4'b0010); chk("vo_c2", valid_out, 0);
        @(negedge clk); chk("first_valid", valid_out, 1);
        consec = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid_out) consec++;
            else break;
        end
        chk("burst_len", consec, 16);
        wait_idle();
        rd(3'd0, 5'd4); rd(3'd1, 5'd4); rd(3'd2, 5'd4); rd(3'd3, 5'd4); rd(3'd4, 5'd16);

        // Single port: pops every other cycle
        @(negedge clk); start_reset();
        for (int k = 0; k < 3; k++) begin load(2, 12'hA01 + 12'(k)); expect_word(2, 12'hA01 + 12'(k)); end
        release_reset();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (pops != 4'b0000) chk("p2_only", pops, 4'b0100);
            if (valid_out) vc.push_back(i);
        end
        chk("p2_words", vc.size(), 3);
        if (vc.size() == 3) begin
            chk("p2_gap1", vc[1] - vc[0], 2);
            chk("p2_gap2", vc[2] - vc[1], 2);
        end
        wait_idle();
        rd(3'd2, 5'd3); rd(3'd4, 5'd3);

        // Pause mid-stream: in-flight words drain, resume at next RR port
        @(negedge clk); start_reset();
        for (int p = 0; p < 4; p++) for (int k = 0; k < 4; k++) load(p, 12'h800 + 12'(p * 16 + k));
        for (int k = 0; k < 4; k++) for (int p = 0; p < 4; p++) expect_word(p, 12'h800 + 12'(p * 16 + k));
        release_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pop2) break;
        end
        chk("pause_pop2_seen", pop2, 1);
        sink_pause = 1'b1;
        delivered = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (valid_out) delivered++;
            chk("paused_nopop", pops, 0);
        end
        chk("inflight_delivered", delivered, 2);
        sink_pause = 1'b0;
        @(negedge clk); chk("resume_p3", pops, 4'b1000);
        wait_idle();
        rd(3'd0, 5'd4); rd(3'd3, 5'd4); rd(3'd4, 5'd16);

        // 33 words via P1: wrap, coincident read, unused index
        @(negedge clk); start_reset();
        for (int k = 0; k < 33; k++) begin load(1, 12'h100 + 12'(k)); expect_word(1, 12'h100 + 12'(k)); end
        release_reset();
        m = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            req = 1'b0;
            if (valid_out) begin
                m++;
                if (m == 5) begin req = 1'b1; idx = 3'd1; rq.push_back(5'd4); end
            end
            if (m == 33) break;
        end
        req = 1'b0;
        chk("p1_words", m, 33);
        wait_idle();
        rd(3'd1, 5'd1); rd(3'd4, 5'd1); rd(3'd0, 5'd0); rd(3'd6, 5'd0);

        // Reset with words in flight
        @(negedge clk); start_reset();
        for (int k = 0; k < 4; k++) begin load(0, 12'h300 + 12'(k)); load(1, 12'h310 + 12'(k)); end
        expect_word(0, 12'h300);
        release_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (valid_out) break;
        end
        chk("t6_valid", valid_out, 1);
        #2 start_reset();
        #1;
        chk("t6_drop_valid", valid_out, 0);
        chk("t6_drop_pops", pops, 0);
        chk("t6_drop_data", data_out, 0);
        release_reset();
        rd(3'd0, 5'd0); rd(3'd1, 5'd0); rd(3'd4, 5'd0);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin load(0, 12'h3A0 + 12'(k)); load(1, 12'h3B0 + 12'(k)); end
        for (int k = 0; k < 2; k++) begin expect_word(0, 12'h3A0 + 12'(k)); expect_word(1, 12'h3B0 + 12'(k)); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (pops != 4'b0000) break;
        end
        chk("t6_restart_p0", pops, 4'b0001);
        wait_idle();
        rd(3'd0, 5'd2); rd(3'd1, 5'd2); rd(3'd4, 5'd4);

        chk("exp_drained", exp_q.size(), 0);
        chk("rd_drained", rq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/qos_fifo_drain.md
Name: qos_fifo_drain

Overview:
Consumer-side drain for the four QoS virtual-channel FIFOs (P0..P3) that sit after the classifier/demux. It watches the FIFO empty flags and issues single-cycle pops in round-robin order. It forwards each popped 12-bit word downstream, tagged with its source port, and honours a downstream pause. It keeps per-port delivered-word counters, read through the same req/idx -> valid/data interface used by the other QoS counter blocks.

Parameters:
DATA_W, 12, width of a FIFO word
CNT_W, 5, width of each delivered-word counter

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
enable  input  1  drain permitted (driven by QoS FSM active_out)
sink_pause  input  1  downstream almost-full; blocks new pops
fifo_empty  input  4  empty flag of FIFO P3..P0 (bit i = Pi)
fifo_dataout0  input  DATA_W  read data of FIFO P0
fifo_dataout1  input  DATA_W  read data of FIFO P1
fifo_dataout2  input  DATA_W  read data of FIFO P2
fifo_dataout3  input  DATA_W  read data of FIFO P3
pop0..pop3  output  1 each  registered pop strobe to FIFO Pi
data_out  output  DATA_W  delivered word
port_out  output  2  source port of data_out
valid_out  output  1  data_out/port_out valid this cycle
req  input  1  counter read request
idx  input  3  counter select
valid  output  1  counter read data valid
data  output  CNT_W  counter read data

Behaviour:
- Reset (reset=0, async):
  - All outputs go to 0: pops, valid_out, data_out, port_out, valid, data.
  - RR pointer = P0. Counters = 0. Lockout cleared. In-flight words are discarded.
- FIFO read timing:
  - Pi samples pop high at the edge ending cycle N.
  - fifo_dataouti holds the word during cycle N+1.
  - The block registers it, so data_out/port_out/valid_out are valid in cycle N+2.
  - Pop-to-valid_out latency is 2 cycles.
  - At most 2 words are in flight; the pipeline tracks the port id alongside each word.
- Pop decision, made in cycle N-1 for a pop in cycle N:
  - Eligible port: fifo_empty[i]=0, enable=1, sink_pause=0, and not popped in cycle N-1 (one-cycle lockout).
  - The lockout prevents popping a FIFO whose last word's empty flag has not yet updated.
  - Grant goes to the first eligible port starting at the RR pointer, ascending with wrap 3->0.
  - On a grant, the pointer moves to grant+1 mod 4.
  - With no eligible port there is no pop and the pointer is held.
  - At most one pop bit is high per cycle.
  - A single non-empty port is therefore popped every other cycle.
  - All 4 ports non-empty gives 1 pop/cycle in order P0,P1,P2,P3,P0...
- sink_pause or enable low in cycle N:
  - No pop in cycle N+1.
  - Already-issued words (up to 2) are still delivered.
  - Deasserting either signal resumes from the held RR pointer.
- Counters: cnt[0..3], CNT_W bits each.
  - cnt[port_out] increments in the cycle after valid_out=1.
  - A separate total counter increments on every delivered word.
  - All counters wrap 31->0 with no saturation.
- Counter read (registered, 1-cycle latency):
  - req=1 in cycle N sets valid=1 in N+1.
  - data = cnt[idx] for idx 0..3; total for idx 4; 0 for idx 5..7.
  - req=0 drives valid=0 and data=0.
  - A read coinciding with an increment returns the pre-increment value.

Test Plan:
1. Reset held low, FIFOs non-empty, enable=1 -> no pops, all outputs 0. On release, first pop0 in cycle 1 and first valid_out 2 cycles later.
2. P0..P3 each hold 4 words (P0: 0FF,404,895,CAE; P1: 15A,55A,95A,D5A; P2: 25A,65A,A5A,E5A; P3: 35A,75A,B5A,F5A), enable=1 -> 16 words on consecutive cycles. Order: 0FF,15A,25A,35A,404,55A,... with port_out cycling 0,1,2,3. Each cnt=4, idx 4 total reads 16.
3. Only P2 holds 3 words -> pop2 high on alternate cycles. valid_out follows with the same spacing, no underflow. cnt[2]=3.
4. All FIFOs full, sink_pause asserted mid-stream -> pops stop the next cycle. Exactly the ≤2 in-flight words are delivered. Release resumes at the next port in RR order with no word lost or duplicated.
5. 33 words through P1 -> cnt[1] reads 1 (wrap). Read with req=1, idx=1 coincident with valid_out for P1 returns the old value. idx=6 returns valid=1, data=0.
6. Reset pulsed low with 2 words in flight -> valid_out drops immediately, counters read 0, RR pointer restarts at P0.
